dht11_sampler: RTL and testbench

Measurement scheduler and result formatter downstream of the DHT11 bus controller. It issues a one-cycle start pulse to the controller every PERIOD_MS and waits for the controller's done pulse. It latches good readings, converts humidity and temperature to 3-digit BCD for the clock's FND display path, and retries on failure or timeout. On timeout it issues a reset pulse to the controller.

---
 rtl/dht11_sampler.sv | 190 +++++++++++++++++++
 tb/tb_dht11_sampler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_sampler.sv
// Measurement scheduler for the DHT11 controller: periodic trigger, retry/timeout handling,
// double-dabble BCD formatting. Define DHT11_SAMPLER_RANGE_CHECK_EN to reject readings outside 20..90 %RH / 0..50 C.
`timescale 1ns/1ps
module dht11_sampler #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int PERIOD_MS  = 2000,
    parameter int TIMEOUT_MS = 50,
    parameter int RETRY_MS   = 100,
    parameter int MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  rh_i,
    input  logic [7:0]  t_i,
    input  logic        done_i,
    input  logic        valid_i,
    output logic        start_o,
    output logic        ctrl_rst_o,
    output logic [11:0] rh_bcd,
    output logic [11:0] t_bcd,
    output logic        update_o,
    output logic        stale_o,
    output logic        busy_o,
    output logic [7:0]  err_cnt
);
    localparam int              DIV      = CLK_HZ / 1000;
    localparam int              PW       = $clog2(DIV + 1);
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT_MS - 1);
    localparam logic [15:0]     RTY_LAST = 16'(RETRY_MS - 1);
    localparam logic [15:0]     PER_LAST = 16'(PERIOD_MS - 1);
    localparam logic [15:0]     PER_FULL = 16'(PERIOD_MS);
    localparam logic [7:0]      MAX_R    = 8'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE, TRIGGER, WAIT_DONE, RETRY_WAIT, CONVERT, WAIT_PERIOD
    } state_t;

    state_t        state;
    logic [PW-1:0] pre;
    logic [15:0]   tmr;
    logic [15:0]   per_cnt;
    logic [7:0]    retry_cnt;
    logic [3:0]    shift_cnt;
    logic [19:0]   rh_sr;
    logic [19:0]   t_sr;
    logic          tick;
    logic          range_ok;
    logic          reading_ok;
    logic          timeout;

    assign tick = enable && (pre == PRE_LAST);

`ifdef DHT11_SAMPLER_RANGE_CHECK_EN
    assign range_ok = (rh_i >= 8'd20) && (rh_i <= 8'd90) && (t_i <= 8'd50);
`else
    assign range_ok = 1'b1;
`endif

    assign reading_ok = valid_i && range_ok;
    assign timeout    = tick && (tmr == TMO_LAST);

    // One double-dabble step on {hundreds, tens, ones, binary}.
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] a;
        a = v;
        if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
        if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
        if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
        return {a[18:0], 1'b0};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pre        <= '0;
            tmr        <= '0;
            per_cnt    <= '0;
            retry_cnt  <= '0;
            shift_cnt  <= '0;
            rh_sr      <= '0;
            t_sr       <= '0;
            start_o    <= 1'b0;
            ctrl_rst_o <= 1'b0;
            rh_bcd     <= '0;
            t_bcd      <= '0;
            update_o   <= 1'b0;
            stale_o    <= 1'b0;
            busy_o     <= 1'b0;
            err_cnt    <= '0;
        end else begin
            start_o    <= 1'b0;
            ctrl_rst_o <= 1'b0;
            update_o   <= 1'b0;
            if (!enable || tick) pre <= '0;
            else                 pre <= pre + PW'(1);
            if (tick && per_cnt != PER_FULL) per_cnt <= per_cnt + 16'd1;
            if (tick && (state == WAIT_DONE || state == RETRY_WAIT)) tmr <= tmr + 16'd1;

            // The prescaler is realigned on every trigger and failure so timeout
            // and retry windows are exact multiples of the ms tick.
            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= TRIGGER;
                        start_o <= 1'b1;
                        busy_o  <= 1'b1;
                        pre     <= '0;
                        tmr     <= '0;
                        per_cnt <= '0;
                    end
                end
                TRIGGER: begin
                    tmr   <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!enable) begin
                        ctrl_rst_o <= 1'b1;
                        busy_o     <= 1'b0;
                        retry_cnt  <= '0;
                        state      <= IDLE;
                    end else if (done_i && reading_ok) begin
                        rh_sr     <= {12'd0, rh_i};
                        t_sr      <= {12'd0, t_i};
                        shift_cnt <= '0;
                        state     <= CONVERT;
                    end else if (done_i || timeout) begin
                        if (!done_i) ctrl_rst_o <= 1'b1;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        pre    <= '0;
                        tmr    <= '0;
                        busy_o <= 1'b0;
                        if (retry_cnt < MAX_R) begin
                            retry_cnt <= retry_cnt + 8'd1;
                            state     <= RETRY_WAIT;
                        end else begin
                            stale_o   <= 1'b1;
                            retry_cnt <= '0;
                            state     <= WAIT_PERIOD;
                        end
                    end
                end
                RETRY_WAIT: begin
                    if (!enable) begin
                        retry_cnt <= '0;
                        state     <= IDLE;
                    end else if (tick && tmr == RTY_LAST) begin
                        state   <= TRIGGER;
                        start_o <= 1'b1;
                        busy_o  <= 1'b1;
                        pre     <= '0;
                        tmr     <= '0;
                    end
                end
                CONVERT: begin
                    if (shift_cnt == 4'd8) begin
                        rh_bcd    <= rh_sr[19:8];
                        t_bcd     <= t_sr[19:8];
                        update_o  <= 1'b1;
                        stale_o   <= 1'b0;
                        retry_cnt <= '0;
                        busy_o    <= 1'b0;
                        state     <= enable ? WAIT_PERIOD : IDLE;
                    end else begin
                        rh_sr     <= dd_step(rh_sr);
                        t_sr      <= dd_step(t_sr);
                        shift_cnt <= shift_cnt + 4'd1;
                    end
                end
                WAIT_PERIOD: begin
                    // A saturated period counter (retries overran it) fires on the next tick.
                    if (!enable) begin
                        state <= IDLE;
                    end else if (tick && per_cnt >= PER_LAST) begin
                        state     <= TRIGGER;
                        start_o   <= 1'b1;
                        busy_o    <= 1'b1;
                        pre       <= '0;
                        tmr       <= '0;
                        per_cnt   <= '0;
                        retry_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dht11_sampler.sv
// Scoreboard bench for dht11_sampler: directed replies push expected BCD results,
// a monitor pops and compares on every update_o pulse.
`timescale 1ns/1ps
module tb_dht11_sampler;
    localparam int CLK_HZ     = 10_000;
    localparam int PERIOD_MS  = 20;
    localparam int TIMEOUT_MS = 5;
    localparam int RETRY_MS   = 2;
    localparam int MAX_RETRY  = 2;
    localparam int W          = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  rh_i;
    logic [7:0]  t_i;
    logic        done_i;
    logic        valid_i;
    logic        start_o;
    logic        ctrl_rst_o;
    logic [11:0] rh_bcd;
    logic [11:0] t_bcd;
    logic        update_o;
    logic        stale_o;
    logic        busy_o;
    logic [7:0]  err_cnt;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          exp_err = 0;
    logic [W-1:0] exp_q[$];
    int          exp_cyc_q[$];

    dht11_sampler #(
        .CLK_HZ(CLK_HZ), .PERIOD_MS(PERIOD_MS), .TIMEOUT_MS(TIMEOUT_MS),
        .RETRY_MS(RETRY_MS), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .rh_i(rh_i), .t_i(t_i),
        .done_i(done_i), .valid_i(valid_i), .start_o(start_o),
        .ctrl_rst_o(ctrl_rst_o), .rh_bcd(rh_bcd), .t_bcd(t_bcd),
        .update_o(update_o), .stale_o(stale_o), .busy_o(busy_o), .err_cnt(err_cnt)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] bcd3(input logic [7:0] v);
        int n;
        n = int'(v);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_start"},   64'(start_o),    64'd0);
        check({name, "_ctrlrst"}, 64'(ctrl_rst_o), 64'd0);
        check({name, "_rh_bcd"},  64'(rh_bcd),     64'd0);
        check({name, "_t_bcd"},   64'(t_bcd),      64'd0);
        check({name, "_update"},  64'(update_o),   64'd0);
        check({name, "_stale"},   64'(stale_o),    64'd0);
        check({name, "_busy"},    64'(busy_o),     64'd0);
        check({name, "_err_cnt"}, 64'(err_cnt),    64'd0);
    endtask

    // mode 0: failed attempt, 1: accepted reading with expected update, 2: accepted but aborted
    task automatic reply(input logic [7:0] rh, input logic [7:0] t, input logic valid, input int mode);
        done_i  = 1'b1;
        valid_i = valid;
        rh_i    = rh;
        t_i     = t;
        if (mode == 1) begin
            exp_q.push_back({bcd3(rh), bcd3(t), 1'b0, 8'(exp_err)});
            exp_cyc_q.push_back(cyc + 10);
        end else if (mode == 0) begin
            exp_err = exp_err + 1;
        end
        @(negedge clk);
        done_i  = 1'b0;
        valid_i = 1'b0;
    endtask

    task automatic wait_for(input bit want_rst, input int budget, input string name, output int at);
        int i;
        at = -1;
        i  = 0;
        while (at < 0 && i < budget) begin
            @(negedge clk);
            i++;
            if ((want_rst ? ctrl_rst_o : start_o) == 1'b1) at = cyc;
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no pulse within %0d cycles", name, budget);
        end
    endtask

    // scoreboard monitor
    initial begin
        logic [W-1:0] e;
        int           ec;
        forever begin
            @(negedge clk);
            if (!rst && update_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_update", 64'd1, 64'd0);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("update_data", 64'({rh_bcd, t_bcd, stale_o, err_cnt}), 64'(e));
                    check("update_cycle", 64'(cyc), 64'(ec));
                end
            end
        end
    end

    // stimulus
    initial begin
        int s, r, c, first, n;
        rst = 1'b1; enable = 1'b0; done_i = 1'b0; valid_i = 1'b0; rh_i = '0; t_i = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // good read and period
        enable = 1'b1;
        c = cyc;
        wait_for(1'b0, 10, "first_start_wait", s);
        check("first_start_latency", 64'(s - c), 64'd1);
        check("busy_in_trigger", 64'(busy_o), 64'd1);
        first = s;
        repeat (3) @(negedge clk);
        reply(8'd45, 8'd23, 1'b1, 1);
        wait_for(1'b0, 300, "period_start_wait", s);
        check("period_gap", 64'(s - first), 64'd200);

        // dead sensor
        first = s;
        for (int k = 0; k < 3; k++) begin
            wait_for(1'b1, 100, "ctrl_rst_wait", r);
            check("timeout_gap", 64'(r - s), 64'd50);
            if (k < 2) begin
                wait_for(1'b0, 100, "retry_start_wait", s);
                check("retry_gap", 64'(s - r), 64'd20);
            end
        end
        exp_err = exp_err + 3;
        check("dead_stale", 64'(stale_o), 64'd1);
        check("dead_err_cnt", 64'(err_cnt), 64'(exp_err));
        check("dead_rh_held", 64'(rh_bcd), 64'h045);
        check("dead_t_held", 64'(t_bcd), 64'h023);
        check("dead_busy", 64'(busy_o), 64'd0);
        wait_for(1'b0, 300, "give_up_period_wait", s);
        check("give_up_period_gap", 64'(s - first), 64'd200);

`ifndef DHT11_SAMPLER_RANGE_CHECK_EN
        // BCD boundaries
        first = s;
        repeat (2) @(negedge clk);
        reply(8'd255, 8'd0, 1'b1, 1);
        wait_for(1'b0, 300, "bcd1_period_wait", s);
        check("bcd1_period_gap", 64'(s - first), 64'd200);
        repeat (5) @(negedge clk);
        reply(8'd99, 8'd100, 1'b1, 1);
        wait_for(1'b0, 300, "bcd2_period_wait", s);
`endif

        // checksum failure then success
        repeat (2) @(negedge clk);
        c = cyc;
        reply(8'd0, 8'd0, 1'b0, 0);
        check("csum_err_cnt", 64'(err_cnt), 64'(exp_err));
        wait_for(1'b0, 60, "csum_retry_wait", s);
        check("csum_retry_gap", 64'(s - c), 64'd21);
        repeat (2) @(negedge clk);
        reply(8'd60, 8'd30, 1'b1, 1);
        repeat (12) @(negedge clk);
        check("csum_stale", 64'(stale_o), 64'd0);
        check("csum_rh_bcd", 64'(rh_bcd), 64'h060);
        wait_for(1'b0, 300, "csum_next_wait", s);

`ifdef DHT11_SAMPLER_RANGE_CHECK_EN
        // out-of-range humidity rejected even with a good checksum
        repeat (2) @(negedge clk);
        c = cyc;
        reply(8'd95, 8'd40, 1'b1, 0);
        check("range_err_cnt", 64'(err_cnt), 64'(exp_err));
        wait_for(1'b0, 60, "range_retry_wait", s);
        check("range_retry_gap", 64'(s - c), 64'd21);
        check("range_rh_held", 64'(rh_bcd), 64'h060);
        repeat (2) @(negedge clk);
        reply(8'd50, 8'd25, 1'b1, 1);
        wait_for(1'b0, 300, "range_next_wait", s);
`endif

        // disable during WAIT_DONE
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("disable_ctrl_rst", 64'(ctrl_rst_o), 64'd1);
        check("disable_busy", 64'(busy_o), 64'd0);
        n = 0;
        repeat (300) begin
            @(negedge clk);
            if (start_o) n++;
        end
        check("disable_no_start", 64'(n), 64'd0);
        check("disable_err_held", 64'(err_cnt), 64'(exp_err));

        // reset during CONVERT
        enable = 1'b1;
        wait_for(1'b0, 5, "reenable_start_wait", s);
        repeat (2) @(negedge clk);
        reply(8'd77, 8'd12, 1'b1, 2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("rst_convert");
        enable = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("pending_updates", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
